axis_elastic_fifo: RTL and testbench

//  Elastic AXI-Stream buffer on the stream path between the DMA engines' ss_* outputs and the

---
 rtl/axis_elastic_fifo_pkg.sv | 16 +
 rtl/axis_fifo_regfile.sv | 26 ++
 rtl/axis_elastic_fifo.sv | 96 +++++++++
 tb/tb_axis_elastic_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_elastic_fifo_pkg.sv
// Shared stream constants for the DMA-to-accelerator elastic buffers.
package axis_elastic_fifo_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  // One elastic buffer sits in front of each accelerator input.
  localparam int FIR_FIFO_DEPTH = 8;
  localparam int MM_FIFO_DEPTH  = 8;
  localparam int QS_FIFO_DEPTH  = 8;

  // Each stored entry carries tlast next to the data word: {tlast, tdata}.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_regfile.sv
// Storage array for the elastic FIFO: one synchronous write port, one asynchronous read port.
// Contents are never cleared; validity is tracked by the controller.
module axis_fifo_regfile
  import axis_elastic_fifo_pkg::*;
#(
  parameter int pDEPTH = 8,
  parameter int pWIDTH = entry_width(AXIS_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(pDEPTH)-1:0] waddr,
  input  logic [pWIDTH-1:0]         wdata,
  input  logic [$clog2(pDEPTH)-1:0] raddr,
  output logic [pWIDTH-1:0]         rdata
);

  logic [pWIDTH-1:0] mem [pDEPTH];

  // Write the incoming entry at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_elastic_fifo.sv
// First-word-fall-through AXI-Stream elastic buffer with per-word tlast,
// occupancy and stored-packet counts for DMA pacing.
module axis_elastic_fifo
  import axis_elastic_fifo_pkg::*;
#(
  parameter int pDATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int pDEPTH      = 8,
  parameter int pAF_THRESH  = 6
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      flush,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [pDATA_WIDTH-1:0]    s_tdata,
  input  logic                      s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [pDATA_WIDTH-1:0]    m_tdata,
  output logic                      m_tlast,
  output logic [$clog2(pDEPTH):0]   level,
  output logic                      almost_full,
  output logic [$clog2(pDEPTH):0]   pkt_cnt
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_width(pDATA_WIDTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(pDEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(pAF_THRESH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          pkt_in;
  logic          pkt_out;
  logic [EW-1:0] rd_entry;

  // Ready/valid come only from occupancy, so neither side sees the other combinationally.
  assign s_tready    = (level != FULL_LEVEL);
  assign m_tvalid    = (level != '0);
  assign almost_full = (level >= AF_LEVEL);

  assign push    = s_tvalid & s_tready;
  assign pop     = m_tvalid & m_tready;
  assign pkt_in  = push & s_tlast;
  assign pkt_out = pop & m_tlast;

  axis_fifo_regfile #(
    .pDEPTH (pDEPTH),
    .pWIDTH (EW)
  ) u_regfile (
    .clk   (wb_clk_i),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata ({s_tlast, s_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign m_tlast = rd_entry[EW-1];
  assign m_tdata = rd_entry[pDATA_WIDTH-1:0];

  // Pointer and counter update; flush drops any handshake taken in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Simulation guard: the ready/valid derivation must make overflow and underflow impossible.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      assert (!(push && level == FULL_LEVEL)) else $error("axis_elastic_fifo overflow");
      assert (!(pop && level == '0)) else $error("axis_elastic_fifo underflow");
    end
  end

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Directed and randomized-backpressure checks for axis_elastic_fifo (depth 4, almost_full at 3).
module tb_axis_elastic_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [2:0]  level;
  logic        almost_full;
  logic [2:0]  pkt_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_elastic_fifo #(
    .pDATA_WIDTH (32),
    .pDEPTH      (4),
    .pAF_THRESH  (3)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .flush       (flush),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .level       (level),
    .almost_full (almost_full),
    .pkt_cnt     (pkt_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%0b exp=1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (pkt_cnt !== 3'd0) begin failures++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%0b exp=0", almost_full); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [5];
    int idx;
    int cyc;
    logic pushed;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44; vals[4] = 32'h55;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vals[i];
      checks++; if (level !== 3'(i)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL fill_s_tready got=%0b exp=1", s_tready); end
      checks++; if (almost_full !== (i >= 3)) begin failures++; $display("FAIL fill_almost_full lvl=%0d got=%0b exp=%0b", i, almost_full, (i >= 3)); end
      step();
    end
    s_tdata = vals[4];
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL full_s_tready got=%0b exp=0", s_tready); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL full_almost_full got=%0b exp=1", almost_full); end
    step();
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL held_level got=%0d exp=4", level); end
    checks++; if (m_tdata !== 32'h11) begin failures++; $display("FAIL held_head got=%h exp=11", m_tdata); end
    m_tready = 1'b1;
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL first_pop_s_tready got=%0b exp=0", s_tready); end
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 20) begin
      pushed = s_tvalid & s_tready;
      if (m_tvalid) begin
        checks++; if (m_tdata !== vals[idx]) begin failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", idx, m_tdata, vals[idx]); end
        idx++;
      end
      step();
      if (cyc == 0) begin
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL after_pop_s_tready got=%0b exp=1", s_tready); end
      end
      if (pushed) s_tvalid = 1'b0;
      cyc++;
    end
    checks++; if (idx !== 5) begin failures++; $display("FAIL drain_timeout got=%0d exp=5", idx); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL drain_m_tvalid got=%0b exp=0", m_tvalid); end
    idle_inputs();
  endtask

  task automatic test_streaming();
    do_reset();
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i == 20) s_tvalid = 1'b0;
      s_tdata = 32'(i);
      if (i == 0) begin
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0b exp=0", m_tvalid); end
      end else begin
        checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL stream_valid i=%0d got=%0b exp=1", i, m_tvalid); end
        checks++; if (m_tdata !== 32'(i - 1)) begin failures++; $display("FAIL stream_data i=%0d got=%0d exp=%0d", i, m_tdata, i - 1); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, level); end
      end
      step();
    end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL stream_end_level got=%0d exp=0", level); end
    idle_inputs();
  endtask

  task automatic test_tlast_pkt();
    logic [31:0] d [4];
    logic        l [4];
    logic [2:0]  pc [3];
    d[0] = 32'hA1; d[1] = 32'hA2; d[2] = 32'hA3; d[3] = 32'hB1;
    l[0] = 1'b0;   l[1] = 1'b0;   l[2] = 1'b1;   l[3] = 1'b1;
    pc[0] = 3'd2;  pc[1] = 3'd2;  pc[2] = 3'd2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = d[i];
      s_tlast  = l[i];
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++; if (pkt_cnt !== 3'd2) begin failures++; $display("FAIL pkt_after_fill got=%0d exp=2", pkt_cnt); end
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_tdata !== d[i]) begin failures++; $display("FAIL pkt_data i=%0d got=%h exp=%h", i, m_tdata, d[i]); end
      checks++; if (m_tlast !== l[i]) begin failures++; $display("FAIL pkt_tlast i=%0d got=%0b exp=%0b", i, m_tlast, l[i]); end
      checks++; if (pkt_cnt !== pc[i]) begin failures++; $display("FAIL pkt_cnt i=%0d got=%0d exp=%0d", i, pkt_cnt, pc[i]); end
      step();
    end
    checks++; if (pkt_cnt !== 3'd1) begin failures++; $display("FAIL pkt_after_a3 got=%0d exp=1", pkt_cnt); end
    s_tvalid = 1'b1;
    s_tdata  = 32'hC1;
    s_tlast  = 1'b1;
    checks++; if (m_tdata !== 32'hB1 || m_tlast !== 1'b1) begin failures++; $display("FAIL pkt_b1 got=%h/%0b exp=b1/1", m_tdata, m_tlast); end
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++; if (pkt_cnt !== 3'd1) begin failures++; $display("FAIL pkt_both got=%0d exp=1", pkt_cnt); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL pkt_both_level got=%0d exp=1", level); end
    checks++; if (m_tdata !== 32'hC1 || m_tlast !== 1'b1) begin failures++; $display("FAIL pkt_c1 got=%h/%0b exp=c1/1", m_tdata, m_tlast); end
    step();
    checks++; if (pkt_cnt !== 3'd0) begin failures++; $display("FAIL pkt_final got=%0d exp=0", pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(i);
      s_tlast  = (i == 2);
      step();
    end
    checks++; if (pkt_cnt !== 3'd1) begin failures++; $display("FAIL flush_pre_pkt got=%0d exp=1", pkt_cnt); end
    flush    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'hEE;
    s_tlast  = 1'b1;
    m_tready = 1'b1;
    step();
    idle_inputs();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (pkt_cnt !== 3'd0) begin failures++; $display("FAIL flush_pkt got=%0d exp=0", pkt_cnt); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL flush_m_tvalid got=%0b exp=0", m_tvalid); end
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL flush_s_tready got=%0b exp=1", s_tready); end
    s_tvalid = 1'b1;
    s_tdata  = 32'h77;
    step();
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h77) begin failures++; $display("FAIL flush_next_word got=%0b/%h exp=1/77", m_tvalid, m_tdata); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL flush_next_level got=%0d exp=1", level); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [32:0] q [$];
    logic [32:0] exp_head;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    logic        do_push;
    logic        do_pop;
    int sent;
    int recv;
    int cyc;
    do_reset();
    sent = 0;
    recv = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      if (!s_tvalid && sent < 1000 && $urandom_range(0, 99) < 60) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tlast  = $urandom_range(0, 3) == 0;
      end
      m_tready = $urandom_range(0, 1) == 1;
      checks++; if (level !== 3'(q.size())) begin failures++; $display("FAIL bp_level cyc=%0d got=%0d exp=%0d", cyc, level, q.size()); end
      checks++; if (s_tready !== (q.size() != 4)) begin failures++; $display("FAIL bp_s_tready cyc=%0d got=%0b exp=%0b", cyc, s_tready, q.size() != 4); end
      checks++; if (m_tvalid !== (q.size() != 0)) begin failures++; $display("FAIL bp_m_tvalid cyc=%0d got=%0b exp=%0b", cyc, m_tvalid, q.size() != 0); end
      if (q.size() != 0) begin
        exp_head = q[0];
        checks++; if ({m_tlast, m_tdata} !== exp_head) begin failures++; $display("FAIL bp_data n=%0d got=%h exp=%h", recv, {m_tlast, m_tdata}, exp_head); end
      end
      if (prev_stall) begin
        checks++; if (m_tdata !== prev_data || m_tlast !== prev_last) begin failures++; $display("FAIL bp_stable got=%h exp=%h", m_tdata, prev_data); end
      end
      do_push = s_tvalid && (q.size() != 4);
      do_pop  = m_tready && (q.size() != 0);
      prev_stall = (q.size() != 0) && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      step();
      if (do_pop) begin
        void'(q.pop_front());
        recv++;
      end
      if (do_push) begin
        q.push_back({s_tlast, s_tdata});
        sent++;
        s_tvalid = 1'b0;
      end
      cyc++;
    end
    checks++; if (recv !== 1000) begin failures++; $display("FAIL bp_timeout got=%0d exp=1000", recv); end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_streaming();
    test_tlast_pkt();
    test_flush();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
